// File: rtl/tone_meter_pkg.sv
// Shared types and constants for the tone period meter and its reciprocal divider.
package tone_meter_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 33;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DIVIDE  = 2'd3
  } state_t;

endpackage

// File: rtl/tone_meter_recip_div.sv
// Restoring serial divider producing floor(2^32 / divisor); done pulses DIV_CYCLES cycles after start.
module recip_div
  import tone_meter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              done
);

  localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 2);

  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic [5:0]        r_cnt;
  logic              r_busy;
  logic              r_done;

  logic [DATA_W:0]   w_trial;
  logic [DATA_W:0]   w_diff;
  logic              w_fits;

  // Dividend bits below the leading one are all zero, so each step just shifts in a 0.
  assign w_trial = {r_rem[DATA_W-1:0], 1'b0};
  assign w_fits  = (w_trial >= {1'b0, r_div});
  assign w_diff  = w_trial - {1'b0, r_div};

  // Dividend MSB step is folded into the load: 1 < divisor, so remainder starts at 1, quotient bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= 6'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_busy <= 1'b0;
        r_cnt  <= 6'd0;
      end else if (start) begin
        r_rem  <= {{DATA_W{1'b0}}, 1'b1};
        r_quo  <= '0;
        r_div  <= divisor;
        r_cnt  <= 6'd0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_fits ? w_diff : w_trial;
        r_quo <= {r_quo[DATA_W-2:0], w_fits};
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == LAST_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/tone_meter.sv
// Measures the period of an asynchronous square wave in clk cycles and
// converts it to a phase-accumulator tuning word floor(2^32 / period).
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter logic [DATA_W-1:0] MAX_PERIOD  = 32'h00FF_FFFF,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tone_in,
  input  logic              enable,
  output logic [DATA_W-1:0] period_out,
  output logic [DATA_W-1:0] scale_out,
  output logic              scale_valid,
  output logic              timeout,
  output logic              busy
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  state_t                 r_state;
  logic [DATA_W-1:0]      r_cnt;
  logic [DATA_W-1:0]      r_meas;
  logic [DATA_W-1:0]      r_period;
  logic [DATA_W-1:0]      r_scale;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_busy;

  logic                   w_edge;
  logic                   w_start;
  logic                   w_abort;
  logic [DATA_W-1:0]      w_quo;
  logic                   w_done;

  // Synchronizer chain plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= SYNC_STAGES'({r_sync, tone_in});
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_start = enable & (r_state == MEASURE) & w_edge;
  assign w_abort = ~enable;

  recip_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .abort    (w_abort),
    .divisor  (r_cnt),
    .quotient (w_quo),
    .done     (w_done)
  );

  // Measurement FSM; an edge coinciding with the counter hitting MAX_PERIOD wins over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_meas    <= '0;
      r_period  <= '0;
      r_scale   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARM;
          end
          ARM: begin
            if (w_edge) begin
              r_cnt   <= 32'd1;
              r_state <= MEASURE;
            end else begin
              r_state <= ARM;
            end
          end
          MEASURE: begin
            if (w_edge) begin
              r_meas  <= r_cnt;
              r_busy  <= 1'b1;
              r_state <= DIVIDE;
            end else if (r_cnt == MAX_PERIOD) begin
              r_period  <= MAX_PERIOD;
              r_scale   <= '0;
              r_timeout <= 1'b1;
              r_valid   <= 1'b1;
              r_state   <= ARM;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          DIVIDE: begin
            if (w_done) begin
              r_period  <= r_meas;
              r_scale   <= w_quo;
              r_timeout <= 1'b0;
              r_valid   <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ARM;
            end else begin
              r_state <= DIVIDE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period_out  = r_period;
  assign scale_out   = r_scale;
  assign scale_valid = r_valid;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule

// File: tb/tb_tone_meter.sv
// Directed self-checking bench for tone_meter (MAX_PERIOD=1000, two sync stages).
module tb_tone_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone_in;
  logic        enable;
  logic [31:0] period_out;
  logic [31:0] scale_out;
  logic        scale_valid;
  logic        timeout;
  logic        busy;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  int          last_rise = 0;
  int          vcyc      = 0;
  int          tone_mode = 0;
  int          tone_per  = 96;
  int          phase     = 0;
  int          c1, c2;
  logic        tone_manual = 1'b0;
  logic        gen_next;
  logic [31:0] acc = 32'd0;
  bit          got;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  tone_meter #(.MAX_PERIOD(32'd1000), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .enable      (enable),
    .period_out  (period_out),
    .scale_out   (scale_out),
    .scale_valid (scale_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  // Tone source: 0 = manual level, 1 = square wave of tone_per cycles, 2 = phase accumulator.
  initial begin
    tone_in = 1'b0;
    forever begin
      @(negedge clk);
      case (tone_mode)
        1:       begin phase = (phase + 1) % tone_per; gen_next = (phase < tone_per / 2); end
        2:       begin acc = acc + 32'h0100_0000; gen_next = acc[31]; end
        default: gen_next = tone_manual;
      endcase
      if (gen_next && !tone_in) last_rise = cyc;
      tone_in = gen_next;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int i;
    got = 1'b0;
    i = 0;
    while (i < budget && !got) begin
      @(posedge clk); #1;
      if (scale_valid === 1'b1) begin
        got  = 1'b1;
        vcyc = cyc;
      end
      i++;
    end
    chk(32'(got), 32'd1, tag);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (scale_valid === 1'b1) cnt++;
    end
  endtask

  task automatic set_tone(input int mode, input int per);
    @(negedge clk);
    enable    = 1'b0;
    tone_mode = mode;
    tone_per  = per;
    repeat (10) @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk(period_out, 32'd0, "rst_period");
    chk(scale_out, 32'd0, "rst_scale");
    chk(32'(scale_valid), 32'd0, "rst_valid");
    chk(32'(timeout), 32'd0, "rst_timeout");
    chk(32'(busy), 32'd0, "rst_busy");
    @(negedge clk) rst_n = 1'b1;

    // Period 96: latency from tone_in rise = 2 sync cycles + 34 after the edge pulse.
    set_tone(1, 96);
    wait_valid(400, "v96");
    chk(32'(vcyc - last_rise), 32'd36, "lat96");
    chk(period_out, 32'd96, "p96");
    chk(scale_out, 32'h02AA_AAAA, "s96");
    chk(32'(timeout), 32'd0, "to96");
    chk(32'(busy), 32'd0, "busy96");
    @(posedge clk); #1;
    chk(32'(scale_valid), 32'd0, "pulse96");

    set_tone(1, 2);
    wait_valid(100, "v2");
    chk(period_out, 32'd2, "p2");
    chk(scale_out, 32'h8000_0000, "s2");
    set_tone(1, 3);
    wait_valid(100, "v3");
    chk(period_out, 32'd3, "p3");
    chk(scale_out, 32'h5555_5555, "s3");

    // Abort 10 cycles into the divide; previous (period 3) result must persist.
    set_tone(1, 96);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) got = 1'b1;
    end
    chk(32'(got), 32'd1, "busy_rise");
    repeat (9) @(posedge clk); #1;
    chk(32'(busy), 32'd1, "busy_mid");
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk(32'(busy), 32'd0, "busy_abort");
    count_valid(60, c1);
    chk(32'(c1), 32'd0, "abort_novalid");
    chk(period_out, 32'd3, "abort_period");
    chk(scale_out, 32'h5555_5555, "abort_scale");
    chk(32'(timeout), 32'd0, "abort_timeout");

    // Edge lands exactly when the counter reaches MAX_PERIOD: valid period, not timeout.
    set_tone(0, 96);
    @(posedge clk); tone_manual = 1'b1;
    repeat (5) @(posedge clk); tone_manual = 1'b0;
    repeat (995) @(posedge clk); tone_manual = 1'b1;
    wait_valid(60, "vmax");
    tone_manual = 1'b0;
    chk(32'(vcyc - last_rise), 32'd36, "latmax");
    chk(period_out, 32'd1000, "pmax");
    chk(scale_out, 32'h0041_8937, "smax");
    chk(32'(timeout), 32'd0, "tomax");

    // One edge then silence: timeout result 1003 cycles after the rise, then ARM forever.
    repeat (10) @(posedge clk); tone_manual = 1'b1;
    repeat (5) @(posedge clk); tone_manual = 1'b0;
    wait_valid(1100, "vto");
    chk(32'(vcyc - last_rise), 32'd1003, "lat_to");
    chk(period_out, 32'd1000, "p_to");
    chk(scale_out, 32'd0, "s_to");
    chk(32'(timeout), 32'd1, "to_to");
    count_valid(1100, c1);
    chk(32'(c1), 32'd0, "arm_quiet");

    // Reset mid-MEASURE clears outputs; restart then needs two edges.
    @(posedge clk); tone_manual = 1'b1;
    repeat (5) @(posedge clk); tone_manual = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk(period_out, 32'd0, "mrst_period");
    chk(scale_out, 32'd0, "mrst_scale");
    chk(32'(timeout), 32'd0, "mrst_timeout");
    chk(32'(busy), 32'd0, "mrst_busy");
    chk(32'(scale_valid), 32'd0, "mrst_valid");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    tone_manual = 1'b1;
    count_valid(5, c1);
    tone_manual = 1'b0;
    count_valid(55, c2);
    tone_manual = 1'b1;
    chk(32'(c1 + c2), 32'd0, "first_edge_arms");
    wait_valid(60, "vrst");
    tone_manual = 1'b0;
    chk(32'(vcyc - last_rise), 32'd36, "lat_rst");
    chk(period_out, 32'd60, "p_rst");
    chk(scale_out, 32'h0444_4444, "s_rst");

    // Loopback from a phase-accumulator generator with tuning word 0x0100_0000.
    set_tone(2, 256);
    wait_valid(800, "vloop");
    chk(period_out, 32'd256, "p_loop");
    chk(scale_out, 32'h0100_0000, "s_loop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tone_meter.md
TONE_METER -- requirements
Module: tone_meter

Interface
REQ-001 SHALL have parameter MAX_PERIOD, default 32'h00FF_FFFF, timeout threshold in clk cycles.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of tone_in synchronizer flops.
REQ-003 Port: clk  input  1  system clock; the block SHALL use this single clock.
REQ-004 Port: rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 Port: tone_in  input  1  asynchronous square wave to measure.
REQ-006 Port: enable  input  1  measurement enable.
REQ-007 Port: period_out  output  32  last measured period in clk cycles.
REQ-008 Port: scale_out  output  32  tuning word floor(2^32 / period_out); 0 on timeout.
REQ-009 Port: scale_valid  output  1  one-cycle pulse when period_out and scale_out update.
REQ-010 Port: timeout  output  1  high when the last result was a timeout.
REQ-011 Port: busy  output  1  high while the divider runs.

Function
REQ-012 SHALL pass tone_in through SYNC_STAGES flops, then detect rising edges with a one-cycle edge pulse.
REQ-013 FSM states SHALL be IDLE, ARM, MEASURE and DIVIDE.
REQ-014 IDLE SHALL move to ARM when enable=1.
REQ-015 ARM SHALL move to MEASURE on an edge pulse and load the counter with 1.
REQ-016 MEASURE SHALL increment the counter once per cycle.
REQ-017 On an edge pulse in MEASURE, the counter value SHALL be latched as the period (tone of P clk cycles -> P), and the FSM SHALL start the divider and enter DIVIDE.
REQ-018 If the counter reaches MAX_PERIOD in MEASURE with no edge, the block SHALL set period_out=MAX_PERIOD, scale_out=0, timeout=1 and pulse scale_valid next cycle, then return to ARM.
REQ-019 The divider SHALL be a restoring serial divider computing floor(2^32 / P) for 2 <= P <= MAX_PERIOD in exactly 33 cycles.
REQ-020 busy SHALL be high for those 33 cycles.
REQ-021 scale_valid SHALL pulse on the 34th cycle after the closing edge pulse, with period_out, scale_out and timeout=0 updated in that same cycle.
REQ-022 After the result, the FSM SHALL return to ARM; edges during DIVIDE SHALL be ignored.
REQ-023 An edge detected in the same cycle the counter reaches MAX_PERIOD SHALL be treated as a valid period, not a timeout.
REQ-024 If enable drops in any state, the FSM SHALL go to IDLE next cycle, abort the divider, clear busy, and not pulse scale_valid.
REQ-025 Outputs period_out, scale_out and timeout SHALL hold their last values until the next scale_valid.
REQ-026 The counter SHALL never wrap; it saturates at MAX_PERIOD.
REQ-027 With no tone_in edges, the block SHALL stay in ARM indefinitely, with no timeout.

Reset
REQ-028 On rst_n=0, asynchronously: FSM=IDLE; synchronizer flops, counter, period_out, scale_out = 0; scale_valid, timeout, busy = 0.
REQ-029 A reset asserted mid-MEASURE or mid-DIVIDE SHALL discard the measurement with no scale_valid pulse.
REQ-030 After rst_n deasserts, the first edge SHALL only arm the block; the first result SHALL require two edges.

Structure
REQ-031 Package tone_meter_pkg SHALL hold the FSM state enum, DIV_CYCLES=33 and the 32-bit width constant.
REQ-032 The divider SHALL be a sub-module recip_div with ports clk, rst_n, start, abort, divisor[31:0], quotient[31:0] and done.
REQ-033 recip_div SHALL have a done pulse 33 cycles after start.
REQ-034 Output scale_out SHALL be directly usable as the tuning word for the team's phase-accumulator tone generator.

Verification
REQ-035 tone_in period 96 clk, 50% duty -> period_out=96, scale_out=32'h02AA_AAAA, timeout=0, scale_valid 34 cycles after second edge.
REQ-036 tone_in period 2 (toggle every cycle, pre-sync) -> period_out=2, scale_out=32'h8000_0000; period 3 -> scale_out=32'h5555_5555.
REQ-037 MAX_PERIOD=1000, one edge then tone_in held low -> scale_valid with period_out=1000, scale_out=0, timeout=1.
REQ-038 enable deasserted 10 cycles into DIVIDE -> busy low next cycle, no scale_valid, previous outputs unchanged.
REQ-039 rst_n pulsed low mid-MEASURE -> all outputs 0 immediately; restart needs two edges before scale_valid.
REQ-040 Loopback: drive tone_in from the tone generator with scale 32'h0100_0000 -> period_out=256, scale_out=32'h0100_0000.
